fifo_arbiter_fsm: RTL and testbench
===================================

Name: fifo_arbiter_fsm

Overview:
Control block for a bank of four 12-bit FIFOs that share one downstream datapath. It programs the FIFO full/empty thresholds, sequences the bank through RESET/INIT/IDLE/ACTIVE/ERROR, and grants reads round-robin among non-empty FIFOs. Reads are throttled by downstream backpressure. The block sits between the upstream FIFO bank and the 4:1 output mux that feeds the next FIFO stage.

Parameters:
NUM_FIFOS, 4, number of arbitrated FIFOs; the design is fixed at 4, and the parameter is for documentation and assertions.
DATA_W, 12, FIFO data width; used only for sizing checks.
UMBRAL_W, 3, width of the threshold fields.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
init  input  1  request threshold (re)programming
full_umbral_in  input  3  almost_full threshold to program
empty_umbral_in  input  3  almost_empty threshold to program
fifo_empty  input  4  empty flag per FIFO
fifo_full  input  4  full flag per FIFO
fifo_wr  input  4  upstream write strobe per FIFO; monitored for overflow
down_almost_full  input  1  almost_full from the downstream FIFO (backpressure)
full_umbral  output  3  registered threshold broadcast to all FIFOs
empty_umbral  output  3  registered threshold broadcast to all FIFOs
fifo_rd  output  4  one-hot read strobe; combinational
sel  output  2  mux select for the read data; registered
data_valid  output  1  read data on the mux output is valid; registered
state  output  3  current FSM state
idle  output  1  high when state is IDLE
error  output  1  high when state is ERROR
error_fifo  output  4  sticky per-FIFO overflow flags

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RESET (000).
  - full_umbral=0, empty_umbral=0, sel=0, data_valid=0, error_fifo=0.
  - Round-robin pointer=0.
  - fifo_rd=0, idle=0, error=0.
  - Reset asserted mid-operation drops all of these immediately, without waiting for a clock edge.
- State encoding: RESET=000, INIT=001, IDLE=010, ACTIVE=011, ERROR=100.
- Overflow (ovf_any = |(fifo_wr & fifo_full)):
  - Evaluated in INIT, IDLE and ACTIVE.
  - Has highest priority: next state is ERROR.
  - error_fifo |= (fifo_wr & fifo_full) at the same edge.
- Transitions:
  - RESET -> INIT on the first edge after reset is released.
  - INIT: on each edge, full_umbral<=full_umbral_in and empty_umbral<=empty_umbral_in. When init=0, go to IDLE; the thresholds latched at that edge are kept.
  - IDLE: init=1 -> INIT; else any fifo_empty bit 0 -> ACTIVE; else stay.
  - ACTIVE: init=1 -> INIT; else fifo_empty==4'b1111 -> IDLE; else stay.
  - ERROR: absorbing; ignores init. Only reset exits.
- Thresholds change only in INIT; they hold in all other states.
- Read grant (fifo_rd):
  - Nonzero only when state==ACTIVE and down_almost_full==0 and at least one FIFO is non-empty.
  - Search order is ptr, ptr+1, ... modulo 4; the first FIFO with fifo_empty=0 is granted.
  - At most one bit is set per cycle. A FIFO flagged empty in the current cycle is never read.
- Pointer: on a grant to index i, ptr<=(i+1) mod 4. With no grant, ptr holds; backpressure does not advance it.
- Read latency: one cycle. On the edge after a grant, data_valid<=1 and sel<=i. Otherwise data_valid<=0 and sel holds its last value.
- Simultaneous events:
  - Overflow and init in the same cycle -> ERROR.
  - A grant issued in the cycle the FSM leaves ACTIVE still produces data_valid on the following edge.
  - Backpressure asserted in the same cycle as a pending grant suppresses that grant.
- Write-side flow control is not gated by this block. Upstream writes to a full FIFO are only detected and reported.
- idle=(state==IDLE) and error=(state==ERROR); both are combinational decodes of the state register.

Test Plan:
1. Asynchronous reset mid-stream: pulse reset=0 during ACTIVE with reads in flight -> state=000, fifo_rd=0, data_valid=0, thresholds=0 before the next edge. On release, the next edge gives state=001.
2. Programming: hold init=1 with full_umbral_in=6, empty_umbral_in=2, then drop init -> full_umbral=6, empty_umbral=2, state=010. Change the *_in inputs afterwards -> outputs stay 6/2. Re-assert init from IDLE -> state=001, new values latched.
3. Round-robin: all FIFOs non-empty, down_almost_full=0 -> fifo_rd sequence 0001,0010,0100,1000,0001. sel follows one cycle later as 0,1,2,3,0, with data_valid=1 throughout.
4. Skip empties: only FIFOs 0 and 2 non-empty -> fifo_rd alternates 0001,0100. When all go empty -> fifo_rd=0, state=010 on the next edge, idle=1.
5. Backpressure: assert down_almost_full while ptr=2 -> fifo_rd=0 in the same cycle, data_valid=0 on the next edge. Deassert -> the first grant is 0100.
6. Overflow: fifo_wr=1000 with fifo_full=1000 while init=1 -> next edge state=100, error=1, error_fifo=1000, fifo_rd stays 0. ERROR persists through init pulses and clears only on reset.

Source files
------------

// File: rtl/fifo_arbiter_fsm_if.sv
// fifo_arbiter_fsm_if: bus between the arbiter and the FIFO bank and output mux.
//   fifo_empty/fifo_full/fifo_wr : per-FIFO status and upstream write strobes
//   down_almost_full             : downstream backpressure
//   fifo_rd                      : one-hot read strobe to the bank
//   sel/data_valid               : output mux select and its valid flag
//   full_umbral/empty_umbral     : threshold broadcast to all FIFOs
// master = arbiter side, slave = FIFO bank / mux side.
interface fifo_arbiter_fsm_if #(
    parameter int NUM_FIFOS = 4,
    parameter int UMBRAL_W  = 3
);
    logic [NUM_FIFOS-1:0]         fifo_empty;
    logic [NUM_FIFOS-1:0]         fifo_full;
    logic [NUM_FIFOS-1:0]         fifo_wr;
    logic                         down_almost_full;
    logic [NUM_FIFOS-1:0]         fifo_rd;
    logic [$clog2(NUM_FIFOS)-1:0] sel;
    logic                         data_valid;
    logic [UMBRAL_W-1:0]          full_umbral;
    logic [UMBRAL_W-1:0]          empty_umbral;

    modport master (
        input  fifo_empty, fifo_full, fifo_wr, down_almost_full,
        output fifo_rd, sel, data_valid, full_umbral, empty_umbral
    );

    modport slave (
        output fifo_empty, fifo_full, fifo_wr, down_almost_full,
        input  fifo_rd, sel, data_valid, full_umbral, empty_umbral
    );
endinterface

// File: rtl/fifo_arbiter_fsm.sv
// fifo_arbiter_fsm: control for a bank of four FIFOs sharing one downstream path.
// Programs thresholds in INIT, sequences RESET/INIT/IDLE/ACTIVE/ERROR, and
// grants reads round-robin among non-empty FIFOs unless downstream is almost full.
// Ports:
//   clk, reset (async, active low)
//   init, full_umbral_in, empty_umbral_in : threshold (re)programming request
//   bus (master)                          : FIFO bank status, read strobe, mux select
//   state, idle, error                    : FSM state and its decodes
//   error_fifo                            : sticky per-FIFO overflow flags
module fifo_arbiter_fsm #(
    parameter int NUM_FIFOS = 4,
    parameter int DATA_W    = 12,
    parameter int UMBRAL_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [UMBRAL_W-1:0]  full_umbral_in,
    input  logic [UMBRAL_W-1:0]  empty_umbral_in,
    fifo_arbiter_fsm_if.master   bus,
    output logic [2:0]           state,
    output logic                 idle,
    output logic                 error,
    output logic [NUM_FIFOS-1:0] error_fifo
);
    localparam logic [2:0] S_RESET  = 3'b000;
    localparam logic [2:0] S_INIT   = 3'b001;
    localparam logic [2:0] S_IDLE   = 3'b010;
    localparam logic [2:0] S_ACTIVE = 3'b011;
    localparam logic [2:0] S_ERROR  = 3'b100;

    localparam int  IDX_W  = $clog2(NUM_FIFOS);
    localparam logic CFG_OK = (NUM_FIFOS == 4) && (DATA_W > 0);

    logic [2:0]           state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt;
    logic [NUM_FIFOS-1:0] rd;
    logic [NUM_FIFOS-1:0] ovf_vec;
    logic                 ovf_any;
    logic                 ovf_chk;

    assign ovf_vec = bus.fifo_wr & bus.fifo_full;
    assign ovf_any = |ovf_vec;
    assign ovf_chk = (state == S_INIT) || (state == S_IDLE) || (state == S_ACTIVE);

    // Round-robin search starting at ptr; first non-empty FIFO wins.
    always_comb begin
        rd      = '0;
        gnt     = 1'b0;
        gnt_idx = ptr;
        idx     = ptr;
        if (state == S_ACTIVE && !bus.down_almost_full) begin
            for (int k = 0; k < NUM_FIFOS; k++) begin
                idx = ptr + IDX_W'(k);
                if (!gnt && !bus.fifo_empty[idx]) begin
                    gnt     = 1'b1;
                    gnt_idx = idx;
                    rd[idx] = 1'b1;
                end
            end
        end
    end

    assign bus.fifo_rd = rd;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  state_nxt = S_INIT;
            S_INIT: begin
                if (ovf_any)    state_nxt = S_ERROR;
                else if (!init) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (ovf_any)                 state_nxt = S_ERROR;
                else if (init)               state_nxt = S_INIT;
                else if (!(&bus.fifo_empty)) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (ovf_any)               state_nxt = S_ERROR;
                else if (init)             state_nxt = S_INIT;
                else if (&bus.fifo_empty)  state_nxt = S_IDLE;
            end
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_RESET;
            bus.full_umbral  <= '0;
            bus.empty_umbral <= '0;
            bus.sel          <= '0;
            bus.data_valid   <= 1'b0;
            error_fifo       <= '0;
            ptr              <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                bus.full_umbral  <= full_umbral_in;
                bus.empty_umbral <= empty_umbral_in;
            end
            if (ovf_chk)
                error_fifo <= error_fifo | ovf_vec;
            // Grant issued this cycle lands on the mux next cycle, even if the FSM leaves ACTIVE.
            bus.data_valid <= gnt;
            if (gnt) begin
                bus.sel <= gnt_idx;
                ptr     <= gnt_idx + IDX_W'(1);
            end
        end
    end

    assign idle  = (state == S_IDLE);
    assign error = (state == S_ERROR);

    a_rd_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.fifo_rd));
    a_cfg:       assert property (@(posedge clk) CFG_OK);
endmodule

// File: tb/tb_fifo_arbiter_fsm.sv
module tb_fifo_arbiter_fsm;
    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] full_umbral_in;
    logic [2:0] empty_umbral_in;
    logic [2:0] state;
    logic       idle;
    logic       error;
    logic [3:0] error_fifo;

    int checks = 0;
    int errors = 0;

    fifo_arbiter_fsm_if bus();

    fifo_arbiter_fsm dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .full_umbral_in  (full_umbral_in),
        .empty_umbral_in (empty_umbral_in),
        .bus             (bus),
        .state           (state),
        .idle            (idle),
        .error           (error),
        .error_fifo      (error_fifo)
    );

    always #5 clk = ~clk;

    // e_rd is checked just before the edge; everything else just after it.
    typedef struct {
        logic       init;
        logic [2:0] fui;
        logic [2:0] eui;
        logic [3:0] empty;
        logic [3:0] full;
        logic [3:0] wr;
        logic       daf;
        logic [3:0] e_rd;
        logic [2:0] e_state;
        logic [1:0] e_sel;
        logic       e_dv;
        logic [2:0] e_fu;
        logic [2:0] e_eu;
        logic [3:0] e_errf;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i, input logic [2:0] fu, input logic [2:0] eu,
                         input logic [3:0] em, input logic [3:0] fl, input logic [3:0] w,
                         input logic d);
        init                 = i;
        full_umbral_in       = fu;
        empty_umbral_in      = eu;
        bus.fifo_empty       = em;
        bus.fifo_full        = fl;
        bus.fifo_wr          = w;
        bus.down_almost_full = d;
    endtask

    initial begin
        //            init fui  eui  empty full  wr    daf  rd    st   sel  dv  fu   eu   errf
        vecs[0]  = '{1'b1, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd1, 2'd0, 1'b0, 3'd0, 3'd0, 4'h0};
        vecs[1]  = '{1'b1, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd1, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[2]  = '{1'b0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[3]  = '{1'b0, 3'd5, 3'd1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[4]  = '{1'b1, 3'd5, 3'd1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd1, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[5]  = '{1'b1, 3'd7, 3'd3, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd1, 2'd0, 1'b0, 3'd7, 3'd3, 4'h0};
        vecs[6]  = '{1'b0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        // round-robin, all non-empty
        vecs[7]  = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd3, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[8]  = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 3'd3, 2'd0, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[9]  = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 3'd3, 2'd1, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[10] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h4, 3'd3, 2'd2, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[11] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h8, 3'd3, 2'd3, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[12] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 3'd3, 2'd0, 1'b1, 3'd6, 3'd2, 4'h0};
        // only FIFOs 0 and 2 non-empty
        vecs[13] = '{1'b0, 3'd6, 3'd2, 4'hA, 4'h0, 4'h0, 1'b0, 4'h4, 3'd3, 2'd2, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[14] = '{1'b0, 3'd6, 3'd2, 4'hA, 4'h0, 4'h0, 1'b0, 4'h1, 3'd3, 2'd0, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[15] = '{1'b0, 3'd6, 3'd2, 4'hA, 4'h0, 4'h0, 1'b0, 4'h4, 3'd3, 2'd2, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[16] = '{1'b0, 3'd6, 3'd2, 4'hA, 4'h0, 4'h0, 1'b0, 4'h1, 3'd3, 2'd0, 1'b1, 3'd6, 3'd2, 4'h0};
        // backpressure with ptr=2
        vecs[17] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 3'd3, 2'd1, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[18] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd3, 2'd1, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[19] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 3'd3, 2'd1, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[20] = '{1'b0, 3'd6, 3'd2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h4, 3'd3, 2'd2, 1'b1, 3'd6, 3'd2, 4'h0};
        // all empty -> IDLE
        vecs[21] = '{1'b0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 2'd2, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[22] = '{1'b0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 2'd2, 1'b0, 3'd6, 3'd2, 4'h0};
        // grant in the cycle ACTIVE is left for INIT still yields data_valid
        vecs[23] = '{1'b0, 3'd6, 3'd2, 4'hE, 4'h0, 4'h0, 1'b0, 4'h0, 3'd3, 2'd2, 1'b0, 3'd6, 3'd2, 4'h0};
        vecs[24] = '{1'b1, 3'd6, 3'd2, 4'hE, 4'h0, 4'h0, 1'b0, 4'h1, 3'd1, 2'd0, 1'b1, 3'd6, 3'd2, 4'h0};
        vecs[25] = '{1'b0, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 3'd2, 2'd0, 1'b0, 3'd6, 3'd2, 4'h0};
        // overflow together with init -> ERROR, absorbing
        vecs[26] = '{1'b1, 3'd6, 3'd2, 4'hF, 4'h8, 4'h8, 1'b0, 4'h0, 3'd4, 2'd0, 1'b0, 3'd6, 3'd2, 4'h8};
        vecs[27] = '{1'b1, 3'd1, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd4, 2'd0, 1'b0, 3'd6, 3'd2, 4'h8};
        vecs[28] = '{1'b0, 3'd1, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 3'd4, 2'd0, 1'b0, 3'd6, 3'd2, 4'h8};

        reset = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 4'hF, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst_dv", 32'(bus.data_valid), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_fu", 32'(bus.full_umbral), 32'd0);
        chk("rst_eu", 32'(bus.empty_umbral), 32'd0);
        chk("rst_errf", 32'(error_fifo), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].init, vecs[i].fui, vecs[i].eui, vecs[i].empty,
                  vecs[i].full, vecs[i].wr, vecs[i].daf);
            #1;
            chk($sformatf("v%0d_rd", i), 32'(bus.fifo_rd), 32'(vecs[i].e_rd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            chk($sformatf("v%0d_sel", i), 32'(bus.sel), 32'(vecs[i].e_sel));
            chk($sformatf("v%0d_dv", i), 32'(bus.data_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d_fu", i), 32'(bus.full_umbral), 32'(vecs[i].e_fu));
            chk($sformatf("v%0d_eu", i), 32'(bus.empty_umbral), 32'(vecs[i].e_eu));
            chk($sformatf("v%0d_errf", i), 32'(error_fifo), 32'(vecs[i].e_errf));
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].e_state == 3'd2));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].e_state == 3'd4));
            @(negedge clk);
        end

        // Reset is the only way out of ERROR; it acts without a clock edge.
        reset = 1'b0;
        #1;
        chk("err_rst_state", 32'(state), 32'd0);
        chk("err_rst_error", 32'(error), 32'd0);
        chk("err_rst_errf", 32'(error_fifo), 32'd0);

        // Bring the bank to ACTIVE with reads in flight, then reset mid-cycle.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 3'd6, 3'd2, 4'hF, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        chk("seq_init", 32'(state), 32'd1);
        @(posedge clk); #1;
        chk("seq_fu", 32'(bus.full_umbral), 32'd6);
        @(negedge clk);
        init = 1'b0;
        @(posedge clk); #1;
        chk("seq_idle", 32'(state), 32'd2);
        @(negedge clk);
        bus.fifo_empty = 4'h0;
        @(posedge clk); #1;
        chk("seq_active", 32'(state), 32'd3);
        @(negedge clk); #1;
        chk("seq_rd0", 32'(bus.fifo_rd), 32'h1);
        @(posedge clk); #1;
        chk("seq_dv0", 32'(bus.data_valid), 32'd1);
        @(negedge clk); #1;
        chk("seq_rd1", 32'(bus.fifo_rd), 32'h2);
        @(posedge clk); #1;
        chk("seq_sel1", 32'(bus.sel), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_rd", 32'(bus.fifo_rd), 32'd0);
        chk("mid_rst_dv", 32'(bus.data_valid), 32'd0);
        chk("mid_rst_sel", 32'(bus.sel), 32'd0);
        chk("mid_rst_fu", 32'(bus.full_umbral), 32'd0);
        chk("mid_rst_eu", 32'(bus.empty_umbral), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
